// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the display scan controller.
//   scan_state_t : scan FSM states (GUARD = all digits dark, SHOW = one digit lit)
//   DIG_*        : digit index constants, also the bit positions in digit_en
//   bcd_digit_t  : one 4-bit BCD digit
//   onehot4      : digit index to one-hot digit enable
package display_scan_controller_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [1:0] DIG_SEC_U = 2'd0;
    localparam logic [1:0] DIG_SEC_T = 2'd1;
    localparam logic [1:0] DIG_MIN_U = 2'd2;
    localparam logic [1:0] DIG_MIN_T = 2'd3;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Bus between the timer counters and the display scan controller.
//   load, second_unit, second_tens, minute_unit, minute_tens, blank : timer -> controller
//   seg_out, digit_en, scan_idx, update_pending, frame_done        : controller -> display/timer
// master: the timer side (drives digits and strobes); slave: the scan controller.
interface display_scan_controller_if;
    import display_scan_controller_pkg::*;

    logic       load;
    bcd_digit_t second_unit;
    bcd_digit_t second_tens;
    bcd_digit_t minute_unit;
    bcd_digit_t minute_tens;
    logic       blank;
    logic [6:0] seg_out;
    logic [3:0] digit_en;
    logic [1:0] scan_idx;
    logic       update_pending;
    logic       frame_done;

    modport master (
        output load, second_unit, second_tens, minute_unit, minute_tens, blank,
        input  seg_out, digit_en, scan_idx, update_pending, frame_done
    );

    modport slave (
        input  load, second_unit, second_tens, minute_unit, minute_tens, blank,
        output seg_out, digit_en, scan_idx, update_pending, frame_done
    );

endinterface

// File: rtl/display_scan_controller_decoder.sv
// SevenSegmentsDecoder: BCD digit to seven-segment pattern, purely combinational.
//   bcd      : 4-bit digit value
//   segments : {g,f,e,d,c,b,a}, 1 = segment lit
// Codes above 9 have no glyph and produce an all-dark pattern.
module display_scan_controller_decoder
    import display_scan_controller_pkg::*;
(
    input  bcd_digit_t bcd,
    output logic [6:0] segments
);

    always_comb begin
        case (bcd)
            4'd0:    segments = 7'h3F;
            4'd1:    segments = 7'h06;
            4'd2:    segments = 7'h5B;
            4'd3:    segments = 7'h4F;
            4'd4:    segments = 7'h66;
            4'd5:    segments = 7'h6D;
            4'd6:    segments = 7'h7D;
            4'd7:    segments = 7'h07;
            4'd8:    segments = 7'h7F;
            4'd9:    segments = 7'h6F;
            default: segments = 7'h00;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for the 4-digit MM:SS seven-segment display.
// Visits digits 0..3 in turn; each visit is a GUARD interval (all dark) followed
// by a SHOW interval (one digit lit). One shared decoder serves all digits.
// Loaded digits land in a pending bank and are copied to the displayed shadow
// bank only at the frame boundary, so a frame never mixes old and new digits.
//   clk, reset : clock, synchronous active-high reset
//   bus        : display_scan_controller_if.slave (digit inputs, load, blank,
//                seg_out, digit_en, scan_idx, update_pending, frame_done)
// Parameters: DWELL_CYCLES (lit cycles per visit), GUARD_CYCLES (dark cycles before each visit).
// Optional macro LEADING_ZERO_BLANK_EN: keeps the minute-tens digit dark while it is 0.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 16
)
(
    input  logic                      clk,
    input  logic                      reset,
    display_scan_controller_if.slave  bus
);

    localparam int CNT_MAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    scan_state_t      state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       idx, idx_next;

    bcd_digit_t pending [4];
    bcd_digit_t shadow  [4];
    logic       update_pending;
    logic [6:0] seg_out_r;
    logic [3:0] digit_en_r;

    logic [6:0] dec_out;
    logic       frame_done_c;
    logic       commit;
    logic [3:0] digit_en_next;

    // State register: reset abandons the frame and restarts at digit 0's guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= GUARD;
            cnt   <= '0;
            idx   <= DIG_SEC_U;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // Next state: the counter restarts on every GUARD/SHOW transition.
    always_comb begin
        next_state = state;
        cnt_next   = cnt + CNT_W'(1);
        idx_next   = idx;
        case (state)
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    next_state = SHOW;
                    cnt_next   = '0;
                end
            end
            SHOW: begin
                if (cnt == DWELL_LAST) begin
                    next_state = GUARD;
                    cnt_next   = '0;
                    idx_next   = idx + 2'd1;
                end
            end
            default: begin
                next_state = GUARD;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decoded from the state: frame boundary, commit and next digit enable.
    always_comb begin
        frame_done_c  = (state == SHOW) && (cnt == DWELL_LAST) && (idx == DIG_MIN_T);
        commit        = frame_done_c && update_pending;
        digit_en_next = '0;
        if ((state == SHOW) && !bus.blank) begin
            digit_en_next = onehot4(idx);
        end
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx == DIG_MIN_T) && (shadow[DIG_MIN_T] == 4'd0)) begin
            digit_en_next = '0;
        end
`endif
    end

    display_scan_controller_decoder u_seven_segments_decoder (
        .bcd      (shadow[idx]),
        .segments (dec_out)
    );

    // Digit banks and output registers. On a load that coincides with the commit,
    // shadow takes the old pending value and update_pending stays set for the new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending        <= '{default: '0};
            shadow         <= '{default: '0};
            update_pending <= 1'b0;
            seg_out_r      <= '0;
            digit_en_r     <= '0;
        end else begin
            if (bus.load) begin
                pending[DIG_SEC_U] <= bus.second_unit;
                pending[DIG_SEC_T] <= bus.second_tens;
                pending[DIG_MIN_U] <= bus.minute_unit;
                pending[DIG_MIN_T] <= bus.minute_tens;
            end
            if (commit) begin
                shadow <= pending;
            end
            if (bus.load) begin
                update_pending <= 1'b1;
            end else if (commit) begin
                update_pending <= 1'b0;
            end
            seg_out_r  <= dec_out;
            digit_en_r <= digit_en_next;
        end
    end

    assign bus.seg_out        = seg_out_r;
    assign bus.digit_en       = digit_en_r;
    assign bus.scan_idx       = idx;
    assign bus.update_pending = update_pending;
    assign bus.frame_done     = frame_done_c;

endmodule
